// File: rtl/updown_range_counter_if.sv
// updown_range_counter_if
// Per-cycle command/status bundle for updown_range_counter.
// There is no valid/ready handshake: every input is sampled on each rising
// clock edge, the counter never stalls and there is no backpressure, and the
// outputs are valid in every cycle.
// The master modport belongs to whatever drives the commands; the slave
// modport belongs to the counter itself.
interface updown_range_counter_if #(
   parameter int unsigned width_p      = 4,
   parameter int unsigned step_width_p = 4
);
   logic                    load_i;
   logic [width_p-1:0]      load_val_i;
   logic                    up_i;
   logic                    down_i;
   logic [step_width_p-1:0] step_i;
   logic                    sat_i;
   logic [width_p-1:0]      count_o;
   logic                    at_max_o;
   logic                    at_min_o;
   logic                    wrap_o;
   logic                    sat_o;

   modport master (
      output load_i, load_val_i, up_i, down_i, step_i, sat_i,
      input  count_o, at_max_o, at_min_o, wrap_o, sat_o
   );

   modport slave (
      input  load_i, load_val_i, up_i, down_i, step_i, sat_i,
      output count_o, at_max_o, at_min_o, wrap_o, sat_o
   );
endinterface

// File: rtl/updown_range_counter.sv
// updown_range_counter
// Up/down counter over the inclusive range [min_val_p, max_val_p] with a
// variable step, a clamped synchronous load and wrap or saturate behaviour
// at the bounds. wrap_o/sat_o are registered one-cycle event pulses.
// Optional feature macro: SAT_MODE_EN. When it is defined, sat_i selects
// saturate (1) or wrap (0) every cycle; when it is undefined the counter
// always wraps and sat_o is tied to 0.
module updown_range_counter #(
   parameter int unsigned min_val_p    = 0,
   parameter int unsigned max_val_p    = 15,
   parameter int unsigned width_p      = $clog2(64'(max_val_p) + 64'd1),
   parameter int unsigned step_width_p = 4,
   parameter int unsigned reset_val_p  = min_val_p
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   updown_range_counter_if.slave bus
);

   // All range arithmetic runs in 33 bits so that count + step and
   // min + step can never overflow, even for a full 32-bit range.
   localparam logic [32:0] c_min   = 33'(min_val_p);
   localparam logic [32:0] c_max   = 33'(max_val_p);
   localparam logic [32:0] c_range = c_max - c_min + 33'd1;
   localparam logic [32:0] c_reset = 33'(reset_val_p);

   // Reject parameter sets the counter cannot honour.
   if (max_val_p <= min_val_p) begin : g_bad_range
      $error("updown_range_counter: max_val_p must exceed min_val_p");
   end
   if (reset_val_p < min_val_p || reset_val_p > max_val_p) begin : g_bad_reset
      $error("updown_range_counter: reset_val_p outside [min_val_p, max_val_p]");
   end
   if (64'(max_val_p) >= (64'd1 << width_p)) begin : g_bad_width
      $error("updown_range_counter: width_p too small to hold max_val_p");
   end

   logic [width_p-1:0] r_count;
   logic               r_wrap;
   logic               r_sat;

   logic [32:0]        w_cnt;
   logic [32:0]        w_step_raw;
   logic [32:0]        w_step;
   logic [32:0]        w_load_raw;
   logic [32:0]        w_load;
   logic [32:0]        w_up_wrap;
   logic [32:0]        w_down_wrap;
   logic               w_up_cross;
   logic               w_down_cross;
   logic               w_do_step;
   logic               w_sat_mode;
   logic [32:0]        w_next;
   logic               w_wrap_nxt;
   logic               w_sat_nxt;

`ifdef SAT_MODE_EN
   assign w_sat_mode = bus.sat_i;
   assign bus.sat_o  = r_sat;
`else
   // sat_i has no effect in this build; the saturate register never sets.
   logic w_unused_sat;
   assign w_sat_mode   = 1'b0;
   assign bus.sat_o    = 1'b0;
   assign w_unused_sat = bus.sat_i ^ r_sat;
`endif

   assign w_cnt      = 33'(r_count);
   assign w_step_raw = 33'(bus.step_i);
   // A step larger than the range is equivalent to a step of exactly R.
   assign w_step     = (w_step_raw > c_range) ? c_range : w_step_raw;
   assign w_load_raw = 33'(bus.load_val_i);
   assign w_load     = (w_load_raw > c_max) ? c_max :
                       (w_load_raw < c_min) ? c_min : w_load_raw;

   // Landing exactly on a bound is not a crossing, hence strict compares.
   assign w_up_cross   = (w_cnt + w_step) > c_max;
   assign w_down_cross = w_cnt < (c_min + w_step);
   assign w_up_wrap    = w_cnt + w_step - c_range;
   assign w_down_wrap  = w_cnt + c_range - w_step;

   // Opposing or absent directions, or a zero step, leave the count alone.
   assign w_do_step = (bus.up_i ^ bus.down_i) && (w_step != 33'd0);

   // Next count and event flags: load beats step, step beats hold.
   always_comb begin
      w_next     = w_cnt;
      w_wrap_nxt = 1'b0;
      w_sat_nxt  = 1'b0;
      if (bus.load_i) begin
         w_next = w_load;
      end else if (w_do_step) begin
         if (bus.up_i) begin
            if (!w_up_cross) begin
               w_next = w_cnt + w_step;
            end else if (w_sat_mode) begin
               w_next    = c_max;
               w_sat_nxt = 1'b1;
            end else begin
               w_next     = w_up_wrap;
               w_wrap_nxt = 1'b1;
            end
         end else begin
            if (!w_down_cross) begin
               w_next = w_cnt - w_step;
            end else if (w_sat_mode) begin
               w_next    = c_min;
               w_sat_nxt = 1'b1;
            end else begin
               w_next     = w_down_wrap;
               w_wrap_nxt = 1'b1;
            end
         end
      end
   end

   // Count and event-flag registers; reset acts immediately.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_count <= width_p'(c_reset);
         r_wrap  <= 1'b0;
         r_sat   <= 1'b0;
      end else begin
         r_count <= width_p'(w_next);
         r_wrap  <= w_wrap_nxt;
         r_sat   <= w_sat_nxt;
      end
   end

   assign bus.count_o  = r_count;
   assign bus.wrap_o   = r_wrap;
   assign bus.at_max_o = (w_cnt == c_max);
   assign bus.at_min_o = (w_cnt == c_min);

endmodule

// File: tb/tb_updown_range_counter.sv
// tb_updown_range_counter
// Directed bench for updown_range_counter with min 3, max 12, reset 5
// (R = 10). Expectations follow SAT_MODE_EN the same way the design does.
module tb_updown_range_counter;

   logic clk_i;
   logic reset_ni;

   updown_range_counter_if #(.width_p(4), .step_width_p(4)) bus ();

   updown_range_counter #(
      .min_val_p    (3),
      .max_val_p    (12),
      .width_p      (4),
      .step_width_p (4),
      .reset_val_p  (5)
   ) dut (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .bus      (bus)
   );

   typedef struct {
      logic       load;
      logic [3:0] load_val;
      logic       up;
      logic       down;
      logic [3:0] step;
      logic       sat;
      logic [3:0] exp_count;
      logic       exp_wrap;
      logic       exp_sat;
   } vec_t;

   vec_t vecs [18];
   int   n_vec;
   int   n_tests;
   int   n_fail;

   // clock / reset
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] ec,
                            input logic ew, input logic es);
      check({tag, " count"},  32'(bus.count_o),  32'(ec));
      check({tag, " wrap"},   32'(bus.wrap_o),   32'(ew));
      check({tag, " sat"},    32'(bus.sat_o),    32'(es));
      check({tag, " at_max"}, 32'(bus.at_max_o), 32'(ec == 4'd12));
      check({tag, " at_min"}, 32'(bus.at_min_o), 32'(ec == 4'd3));
   endtask

   task automatic drive(input logic l, input logic [3:0] lv, input logic u,
                        input logic d, input logic [3:0] st, input logic sa);
      bus.load_i     = l;
      bus.load_val_i = lv;
      bus.up_i       = u;
      bus.down_i     = d;
      bus.step_i     = st;
      bus.sat_i      = sa;
   endtask

   // one clock: inputs were set at a negedge, result sampled at the next
   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic add_vec(input logic l, input logic [3:0] lv, input logic u,
                          input logic d, input logic [3:0] st, input logic sa,
                          input logic [3:0] ec, input logic ew, input logic es);
      vecs[n_vec] = '{l, lv, u, d, st, sa, ec, ew, es};
      n_vec++;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      n_vec   = 0;

      // vector table: load, load_val, up, down, step, sat -> count, wrap, sat
      add_vec(1'b1, 4'd11, 1'b0, 1'b0, 4'd0,  1'b0, 4'd11, 1'b0, 1'b0);
      add_vec(1'b0, 4'd0,  1'b1, 1'b0, 4'd3,  1'b0, 4'd4,  1'b1, 1'b0);
      add_vec(1'b0, 4'd0,  1'b0, 1'b0, 4'd3,  1'b0, 4'd4,  1'b0, 1'b0);
`ifdef SAT_MODE_EN
      add_vec(1'b0, 4'd0,  1'b0, 1'b1, 4'd5,  1'b1, 4'd3,  1'b0, 1'b1);
      add_vec(1'b0, 4'd0,  1'b0, 1'b1, 4'd5,  1'b1, 4'd3,  1'b0, 1'b1);
`else
      add_vec(1'b0, 4'd0,  1'b0, 1'b1, 4'd5,  1'b1, 4'd9,  1'b1, 1'b0);
      add_vec(1'b0, 4'd0,  1'b0, 1'b1, 4'd5,  1'b1, 4'd4,  1'b0, 1'b0);
`endif
      add_vec(1'b1, 4'd14, 1'b1, 1'b0, 4'd1,  1'b0, 4'd12, 1'b0, 1'b0);
      add_vec(1'b0, 4'd0,  1'b1, 1'b1, 4'd2,  1'b0, 4'd12, 1'b0, 1'b0);
      add_vec(1'b0, 4'd0,  1'b1, 1'b0, 4'd0,  1'b0, 4'd12, 1'b0, 1'b0);
`ifdef SAT_MODE_EN
      add_vec(1'b0, 4'd0,  1'b1, 1'b0, 4'd1,  1'b1, 4'd12, 1'b0, 1'b1);
`else
      add_vec(1'b0, 4'd0,  1'b1, 1'b0, 4'd1,  1'b1, 4'd3,  1'b1, 1'b0);
`endif
      add_vec(1'b1, 4'd0,  1'b0, 1'b0, 4'd0,  1'b0, 4'd3,  1'b0, 1'b0);
      add_vec(1'b1, 4'd7,  1'b0, 1'b0, 4'd0,  1'b0, 4'd7,  1'b0, 1'b0);
      add_vec(1'b0, 4'd0,  1'b1, 1'b0, 4'd10, 1'b0, 4'd7,  1'b1, 1'b0);
      add_vec(1'b0, 4'd0,  1'b1, 1'b0, 4'd15, 1'b0, 4'd7,  1'b1, 1'b0);
      add_vec(1'b0, 4'd0,  1'b0, 1'b1, 4'd10, 1'b0, 4'd7,  1'b1, 1'b0);
      add_vec(1'b0, 4'd0,  1'b1, 1'b0, 4'd5,  1'b0, 4'd12, 1'b0, 1'b0);
      add_vec(1'b0, 4'd0,  1'b0, 1'b1, 4'd9,  1'b0, 4'd3,  1'b0, 1'b0);
      add_vec(1'b0, 4'd0,  1'b0, 1'b1, 4'd1,  1'b0, 4'd12, 1'b1, 1'b0);
`ifdef SAT_MODE_EN
      add_vec(1'b0, 4'd0,  1'b0, 1'b1, 4'd15, 1'b1, 4'd3,  1'b0, 1'b1);
`else
      add_vec(1'b0, 4'd0,  1'b0, 1'b1, 4'd15, 1'b1, 4'd12, 1'b1, 1'b0);
`endif

      // reset state
      drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      reset_ni = 1'b0;
      #12;
      check_all("reset", 4'd5, 1'b0, 1'b0);
      @(negedge clk_i);
      reset_ni = 1'b1;

      // count up by one, then reset asynchronously in mid-cycle
      drive(1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0);
      tick();
      check_all("up1", 4'd6, 1'b0, 1'b0);
      tick();
      check_all("up2", 4'd7, 1'b0, 1'b0);
      #2 reset_ni = 1'b0;
      #1 check_all("async_rst", 4'd5, 1'b0, 1'b0);
      tick();
      check_all("rst_held", 4'd5, 1'b0, 1'b0);
      reset_ni = 1'b1;
      tick();
      check_all("resume", 4'd6, 1'b0, 1'b0);

      // reset clears a pending wrap pulse immediately
      drive(1'b1, 4'd12, 1'b0, 1'b0, 4'd0, 1'b0);
      tick();
      drive(1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0);
      tick();
      check_all("pre_rst_wrap", 4'd3, 1'b1, 1'b0);
      #2 reset_ni = 1'b0;
      #1 check_all("rst_clr_wrap", 4'd5, 1'b0, 1'b0);
      @(negedge clk_i);
      drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      reset_ni = 1'b1;

      // table-driven vectors
      for (int i = 0; i < n_vec; i++) begin
         drive(vecs[i].load, vecs[i].load_val, vecs[i].up, vecs[i].down,
               vecs[i].step, vecs[i].sat);
         tick();
         check_all($sformatf("vec%0d", i), vecs[i].exp_count,
                   vecs[i].exp_wrap, vecs[i].exp_sat);
      end

      // a pulse lasts exactly one cycle once events stop
      drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      tick();
`ifdef SAT_MODE_EN
      check_all("pulse_end", 4'd3, 1'b0, 1'b0);
`else
      check_all("pulse_end", 4'd12, 1'b0, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/updown_range_counter.md
# updown_range_counter

- Parametrised up/down counter over an arbitrary inclusive range [min_val_p, max_val_p].
- Adds a variable step, synchronous load, and per-cycle wrap/saturate selection.
- Registered wrap and saturate event flags, plus combinational range-bound flags.
- Successor to the fixed step-1, zero-based circular counter; used for pointer generation, credit tracking and modulo sequencing.

## Interface
Parameters:
- min_val_p, default 0: lower bound of the count range, inclusive; 32-bit unsigned.
- max_val_p, default 15: upper bound, inclusive; 32-bit unsigned; must be greater than min_val_p.
- width_p, default $clog2(max_val_p+1): count width; always holds max_val_p.
- step_width_p, default 4: width of step_i.
- reset_val_p, default min_val_p: value loaded on reset; must lie in range, otherwise elaboration $error.

Ports:
- clk_i, input, 1: clock; all state updates on the rising edge.
- reset_ni, input, 1: asynchronous, active-low reset.
- load_i, input, 1: synchronous load of load_val_i.
- load_val_i, input, width_p: load value; clamped into [min,max].
- up_i, input, 1: count up by step_i.
- down_i, input, 1: count down by step_i.
- step_i, input, step_width_p: step magnitude.
- sat_i, input, 1: 1 = saturate at the bounds, 0 = wrap (macro dependent, see Configuration).
- count_o, output, width_p: current count, registered.
- at_max_o, output, 1: combinational, count_o == max_val_p.
- at_min_o, output, 1: combinational, count_o == min_val_p.
- wrap_o, output, 1: registered one-cycle pulse; the last update wrapped.
- sat_o, output, 1: registered one-cycle pulse; the last update was clipped at a bound.

## Operation
- Define R = max_val_p − min_val_p + 1 (the range size).
- Define the effective step s = min(step_i, R). Arithmetic is done in 33 bits, so there is no intermediate overflow.
- Priority is fixed as: reset > load > step > hold.
- Load: count ← clamp(load_val_i, min, max). wrap_o and sat_o are 0.
- Step occurs when exactly one of up_i or down_i is set and s ≠ 0.
- Hold applies when both up_i and down_i are set, neither is set, or s = 0. count is unchanged and wrap_o and sat_o are 0.
- Up step, no bound crossed (count + s ≤ max): count ← count + s.
- Up step, bound crossed, wrap mode: count ← count + s − R, wrap_o ← 1.
- Up step, bound crossed, saturate mode: count ← max, sat_o ← 1.
- Down step, no bound crossed (count − s ≥ min): count ← count − s.
- Down step, bound crossed, wrap mode: count ← count − s + R, wrap_o ← 1.
- Down step, bound crossed, saturate mode: count ← min, sat_o ← 1.
- A step of exactly R in wrap mode returns the same count and asserts wrap_o.
- A step landing exactly on a bound is not a crossing: no flag is raised.
- Saturating while already at the bound still pulses sat_o, provided s ≠ 0.

## Timing
- Reset (reset_ni low) takes effect immediately, independent of clk_i:
  - count_o = reset_val_p
  - wrap_o = 0
  - sat_o = 0
  - at_max_o and at_min_o follow count_o.
- Reset asserted mid-operation discards any in-flight update.
- The first update occurs on the first rising edge after reset_ni deasserts. Deassertion is synchronised externally.
- Latency is one cycle: the inputs sampled at edge N appear on count_o, wrap_o and sat_o after edge N.
- wrap_o and sat_o are high for exactly one cycle per event. Back-to-back events hold them high continuously.
- at_max_o and at_min_o have zero latency relative to count_o. Both are high only if R = 1, which is disallowed.

## Configuration
- SAT_MODE_EN defined: sat_i is honoured per cycle as described in Operation.
- SAT_MODE_EN undefined: sat_i is ignored, the counter always wraps, and sat_o is tied to 0.

## Test plan
- Reset: min 3, max 12, reset_val_p 5. Pulse reset_ni low mid-count with up_i held → count_o = 5 asynchronously, wrap_o and sat_o 0; counting resumes on the first edge after release.
- Up wrap: count 11, step 3, up_i, sat_i 0 → count 4 (11+3−10), wrap_o high for one cycle.
- Down saturate (SAT_MODE_EN defined): count 4, step 5, down_i, sat_i 1 → count 3, sat_o pulse. Repeat the same step → count 3, sat_o pulses again.
- Load, priority and clamp:
  - load_i with up_i and load_val_i 14 → count 12 (clamped), no flags.
  - up_i and down_i together → hold.
  - step 0 → hold.
- Full-range step: step 10 (= R) in wrap mode from count 7 → count stays 7, wrap_o = 1. Step 15 is clamped to 10 and gives the same result.
- Macro off: SAT_MODE_EN undefined, sat_i 1, count 12, step 1 up → count 3, wrap_o = 1, sat_o = 0.
